// File: rtl/tx_trn_arbiter.sv
// tx_trn_arbiter
//   Shares one 64-bit TRN transmit interface among NUM_REQ TLP generators.
//   Turns are offered round-robin over the my_turn / driving_interface
//   handshake; the current owner's TRN and cfg_interrupt_n signals are muxed
//   onto the core with no added latency. Handshake violations and over-long
//   ownership are flagged with sticky status bits.
//
// Ports
//   trn_clk              TRN clock
//   reset                asynchronous, active-high reset
//   my_turn              one-hot turn offer (registered)
//   driving_interface    per-requester "I hold the interface"
//   req_trn_*            per-requester TRN buses, slice i = requester i
//   req_cfg_interrupt_n  per-requester interrupt request (active low)
//   trn_*                muxed TRN signals to the core
//   cfg_interrupt_n      muxed interrupt request to the core
//   owner                currently granted/offered index
//   protocol_error       sticky: a non-owner drove the interface
//   own_timeout          sticky: ownership lasted MAX_OWN cycles
module tx_trn_arbiter #(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned IDX_W        = 2,
    parameter int unsigned GRANT_WINDOW = 4,
    parameter int unsigned MAX_OWN      = 1024
) (
    input  logic                   trn_clk,
    input  logic                   reset,
    output logic [NUM_REQ-1:0]     my_turn,
    input  logic [NUM_REQ-1:0]     driving_interface,
    input  logic [64*NUM_REQ-1:0]  req_trn_td,
    input  logic [8*NUM_REQ-1:0]   req_trn_trem_n,
    input  logic [NUM_REQ-1:0]     req_trn_tsof_n,
    input  logic [NUM_REQ-1:0]     req_trn_teof_n,
    input  logic [NUM_REQ-1:0]     req_trn_tsrc_rdy_n,
    input  logic [NUM_REQ-1:0]     req_cfg_interrupt_n,
    output logic [63:0]            trn_td,
    output logic [7:0]             trn_trem_n,
    output logic                   trn_tsof_n,
    output logic                   trn_teof_n,
    output logic                   trn_tsrc_rdy_n,
    output logic                   cfg_interrupt_n,
    output logic [IDX_W-1:0]       owner,
    output logic                   protocol_error,
    output logic                   own_timeout
);

    localparam int unsigned WIN_W = $clog2(GRANT_WINDOW);
    localparam int unsigned OWN_W = $clog2(MAX_OWN + 1);

    typedef enum logic [1:0] {
        OFFER,
        OWNED,
        GAP
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr;
    logic [WIN_W-1:0]   win_cnt;
    logic [OWN_W-1:0]   own_cnt;
    logic [NUM_REQ-1:0] owner_mask;
    logic               stray;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (i == IDX_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NUM_REQ-1:0] v;
        v = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (i == IDX_W'(k)) begin
                v[k] = 1'b1;
            end
        end
        return v;
    endfunction

    // Any requester other than the owner that claims the interface or
    // asserts source-ready is a handshake violation; its inputs never reach
    // the mux because the select follows the owner register only.
    always_comb begin
        owner_mask = onehot(owner);
        stray      = (|(driving_interface & ~owner_mask)) |
                     (|(~req_trn_tsrc_rdy_n & ~owner_mask));
    end

    always_ff @(posedge trn_clk or posedge reset) begin
        if (reset) begin
            state          <= OFFER;
            rr             <= '0;
            owner          <= '0;
            my_turn        <= '0;
            win_cnt        <= '0;
            own_cnt        <= '0;
            protocol_error <= 1'b0;
            own_timeout    <= 1'b0;
        end else begin
            if (stray) begin
                protocol_error <= 1'b1;
            end

            case (state)
                OFFER: begin
                    // Ownership is tested before window expiry so a claim on
                    // the last offered cycle wins and rr does not advance.
                    if (driving_interface[rr]) begin
                        state   <= OWNED;
                        my_turn <= '0;
                        win_cnt <= '0;
                        own_cnt <= '0;
                        owner   <= rr;
                    end else if (my_turn == '0) begin
                        // First cycle out of reset: raise the offer without
                        // counting, so every window shows my_turn for
                        // GRANT_WINDOW full cycles.
                        my_turn <= onehot(rr);
                        owner   <= rr;
                    end else if (win_cnt == WIN_W'(GRANT_WINDOW - 1)) begin
                        rr      <= next_idx(rr);
                        owner   <= next_idx(rr);
                        my_turn <= onehot(next_idx(rr));
                        win_cnt <= '0;
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                    end
                end

                OWNED: begin
                    my_turn <= '0;
                    if (driving_interface[owner]) begin
                        if (own_cnt != OWN_W'(MAX_OWN)) begin
                            own_cnt <= own_cnt + 1'b1;
                        end
                        if (own_cnt == OWN_W'(MAX_OWN - 1)) begin
                            own_timeout <= 1'b1;
                        end
                    end else begin
                        rr      <= next_idx(owner);
                        own_cnt <= '0;
                        state   <= GAP;
                    end
                end

                GAP: begin
                    state   <= OFFER;
                    my_turn <= onehot(rr);
                    owner   <= rr;
                    win_cnt <= '0;
                end

                default: begin
                    state   <= OFFER;
                    my_turn <= '0;
                end
            endcase
        end
    end

    // Zero-latency output mux. Reset is folded in so the core sees the idle
    // pattern the moment reset asserts, even though owner resets to 0.
    always_comb begin
        trn_td          = '0;
        trn_trem_n      = '1;
        trn_tsof_n      = 1'b1;
        trn_teof_n      = 1'b1;
        trn_tsrc_rdy_n  = 1'b1;
        cfg_interrupt_n = 1'b1;
        if (!reset && (state != GAP)) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (owner == IDX_W'(k)) begin
                    trn_td          = req_trn_td[64*k +: 64];
                    trn_trem_n      = req_trn_trem_n[8*k +: 8];
                    trn_tsof_n      = req_trn_tsof_n[k];
                    trn_teof_n      = req_trn_teof_n[k];
                    trn_tsrc_rdy_n  = req_trn_tsrc_rdy_n[k];
                    cfg_interrupt_n = req_cfg_interrupt_n[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_tx_trn_arbiter.sv
// tb_tx_trn_arbiter
//   Directed bench for tx_trn_arbiter (NUM_REQ=3, GRANT_WINDOW=4, MAX_OWN=8).
//   Inputs change 1 time unit after the rising edge, mimicking registered
//   requester outputs; outputs are sampled in the same quiet region.
module tb_tx_trn_arbiter;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned IDX_W   = 2;

    logic                  trn_clk;
    logic                  reset;
    logic [NUM_REQ-1:0]    my_turn;
    logic [NUM_REQ-1:0]    driving_interface;
    logic [64*NUM_REQ-1:0] req_trn_td;
    logic [8*NUM_REQ-1:0]  req_trn_trem_n;
    logic [NUM_REQ-1:0]    req_trn_tsof_n;
    logic [NUM_REQ-1:0]    req_trn_teof_n;
    logic [NUM_REQ-1:0]    req_trn_tsrc_rdy_n;
    logic [NUM_REQ-1:0]    req_cfg_interrupt_n;
    logic [63:0]           trn_td;
    logic [7:0]            trn_trem_n;
    logic                  trn_tsof_n;
    logic                  trn_teof_n;
    logic                  trn_tsrc_rdy_n;
    logic                  cfg_interrupt_n;
    logic [IDX_W-1:0]      owner;
    logic                  protocol_error;
    logic                  own_timeout;

    int checks = 0;
    int errors = 0;

    tx_trn_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .IDX_W        (IDX_W),
        .GRANT_WINDOW (4),
        .MAX_OWN      (8)
    ) dut (
        .trn_clk             (trn_clk),
        .reset               (reset),
        .my_turn             (my_turn),
        .driving_interface   (driving_interface),
        .req_trn_td          (req_trn_td),
        .req_trn_trem_n      (req_trn_trem_n),
        .req_trn_tsof_n      (req_trn_tsof_n),
        .req_trn_teof_n      (req_trn_teof_n),
        .req_trn_tsrc_rdy_n  (req_trn_tsrc_rdy_n),
        .req_cfg_interrupt_n (req_cfg_interrupt_n),
        .trn_td              (trn_td),
        .trn_trem_n          (trn_trem_n),
        .trn_tsof_n          (trn_tsof_n),
        .trn_teof_n          (trn_teof_n),
        .trn_tsrc_rdy_n      (trn_tsrc_rdy_n),
        .cfg_interrupt_n     (cfg_interrupt_n),
        .owner               (owner),
        .protocol_error      (protocol_error),
        .own_timeout         (own_timeout)
    );

    initial trn_clk = 1'b0;
    always #5 trn_clk = ~trn_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge trn_clk);
        #1;
    endtask

    task automatic idle_inputs();
        driving_interface   = '0;
        req_trn_td          = '0;
        req_trn_trem_n      = '1;
        req_trn_tsof_n      = '1;
        req_trn_teof_n      = '1;
        req_trn_tsrc_rdy_n  = '1;
        req_cfg_interrupt_n = '1;
    endtask

    // Bounded wait for the offer to reach requester idx.
    task automatic wait_for_turn(input int unsigned idx);
        logic [NUM_REQ-1:0] want;
        bit found;
        want  = 3'b001 << idx;
        found = 0;
        for (int n = 0; n < 16 && !found; n++) begin
            step();
            if (my_turn === want) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_turn%0d: my_turn=%b never reached %b", idx, my_turn, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        req_trn_td[63:0]       = 64'hDEAD_BEEF;
        req_trn_trem_n[7:0]    = 8'h00;
        req_trn_tsof_n[0]      = 1'b0;
        req_cfg_interrupt_n[0] = 1'b0;
        step(); step(); step();
        checks++; if (my_turn !== 3'b000) begin errors++; $display("FAIL rst_my_turn: got %b want 000", my_turn); end
        checks++; if (owner !== 2'd0) begin errors++; $display("FAIL rst_owner: got %0d want 0", owner); end
        checks++; if (trn_td !== 64'h0) begin errors++; $display("FAIL rst_td: got %h want 0", trn_td); end
        checks++; if (trn_trem_n !== 8'hFF) begin errors++; $display("FAIL rst_trem: got %h want ff", trn_trem_n); end
        checks++; if (trn_tsof_n !== 1'b1) begin errors++; $display("FAIL rst_tsof: got %b want 1", trn_tsof_n); end
        checks++; if (trn_tsrc_rdy_n !== 1'b1) begin errors++; $display("FAIL rst_tsrc: got %b want 1", trn_tsrc_rdy_n); end
        checks++; if (cfg_interrupt_n !== 1'b1) begin errors++; $display("FAIL rst_cfg_int: got %b want 1", cfg_interrupt_n); end
        checks++; if (protocol_error !== 1'b0) begin errors++; $display("FAIL rst_perr: got %b want 0", protocol_error); end
        checks++; if (own_timeout !== 1'b0) begin errors++; $display("FAIL rst_tmo: got %b want 0", own_timeout); end
        idle_inputs();
        #2;
        reset = 1'b0;
    endtask

    task automatic test_rotation();
        int unsigned e;
        logic [NUM_REQ-1:0] want;
        for (int k = 0; k < 16; k++) begin
            step();
            e    = (k / 4) % 3;
            want = 3'b001 << e;
            checks++; if (my_turn !== want) begin errors++; $display("FAIL rot_my_turn[%0d]: got %b want %b", k, my_turn, want); end
            checks++; if (owner !== IDX_W'(e)) begin errors++; $display("FAIL rot_owner[%0d]: got %0d want %0d", k, owner, e); end
            checks++; if (trn_td !== 64'h0 || trn_tsrc_rdy_n !== 1'b1) begin errors++; $display("FAIL rot_idle[%0d]: td=%h tsrc=%b want 0/1", k, trn_td, trn_tsrc_rdy_n); end
        end
    endtask

    task automatic test_handshake();
        step();
        checks++; if (my_turn !== 3'b010) begin errors++; $display("FAIL hs_offer: got %b want 010", my_turn); end
        step();
        driving_interface[1]  = 1'b1;
        req_trn_td[127:64]    = 64'hA5;
        req_trn_trem_n[15:8]  = 8'h0F;
        req_trn_tsof_n[1]     = 1'b0;
        req_trn_tsrc_rdy_n[1] = 1'b0;
        #1;
        checks++; if (trn_td !== 64'hA5) begin errors++; $display("FAIL hs_td0: got %h want a5", trn_td); end
        checks++; if (trn_trem_n !== 8'h0F) begin errors++; $display("FAIL hs_trem: got %h want 0f", trn_trem_n); end
        checks++; if (trn_tsof_n !== 1'b0 || trn_tsrc_rdy_n !== 1'b0) begin errors++; $display("FAIL hs_sof: tsof=%b tsrc=%b want 0/0", trn_tsof_n, trn_tsrc_rdy_n); end
        checks++; if (my_turn !== 3'b010) begin errors++; $display("FAIL hs_turn_held: got %b want 010", my_turn); end
        step();
        checks++; if (my_turn !== 3'b000) begin errors++; $display("FAIL hs_owned_turn: got %b want 000", my_turn); end
        checks++; if (trn_td !== 64'hA5) begin errors++; $display("FAIL hs_td1: got %h want a5", trn_td); end
        req_trn_tsof_n[1] = 1'b1;
        step();
        req_trn_teof_n[1] = 1'b0;
        #1;
        checks++; if (trn_teof_n !== 1'b0 || owner !== 2'd1) begin errors++; $display("FAIL hs_eof: teof=%b owner=%0d want 0/1", trn_teof_n, owner); end
        step();
        driving_interface[1]  = 1'b0;
        req_trn_tsrc_rdy_n[1] = 1'b1;
        req_trn_teof_n[1]     = 1'b1;
        step();
        checks++; if (my_turn !== 3'b000) begin errors++; $display("FAIL hs_gap_turn: got %b want 000", my_turn); end
        checks++; if (trn_td !== 64'h0 || trn_trem_n !== 8'hFF) begin errors++; $display("FAIL hs_gap_idle: td=%h trem=%h want 0/ff", trn_td, trn_trem_n); end
        req_trn_td[127:64]   = '0;
        req_trn_trem_n[15:8] = 8'hFF;
        step();
        checks++; if (my_turn !== 3'b100 || owner !== 2'd2) begin errors++; $display("FAIL hs_next_offer: turn=%b owner=%0d want 100/2", my_turn, owner); end
    endtask

    task automatic test_interrupt();
        req_cfg_interrupt_n[0] = 1'b0;
        #1;
        checks++; if (cfg_interrupt_n !== 1'b0) begin errors++; $display("FAIL int_owner: got %b want 0", cfg_interrupt_n); end
        req_cfg_interrupt_n[0] = 1'b1;
        req_cfg_interrupt_n[1] = 1'b0;
        #1;
        checks++; if (cfg_interrupt_n !== 1'b1) begin errors++; $display("FAIL int_nonowner: got %b want 1", cfg_interrupt_n); end
        req_cfg_interrupt_n[1] = 1'b1;
    endtask

    task automatic test_protocol_error();
        wait_for_turn(0);
        step();
        driving_interface[0]  = 1'b1;
        req_trn_td[63:0]      = 64'h0123_4567_89AB_CDEF;
        req_trn_tsrc_rdy_n[0] = 1'b0;
        step();
        checks++; if (protocol_error !== 1'b0 || my_turn !== 3'b000) begin errors++; $display("FAIL perr_clean: perr=%b turn=%b want 0/000", protocol_error, my_turn); end
        driving_interface[2]  = 1'b1;
        req_trn_td[191:128]   = 64'hBAD;
        req_trn_tsrc_rdy_n[2] = 1'b0;
        #1;
        checks++; if (trn_td !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL perr_mux0: got %h want 0123456789abcdef", trn_td); end
        step();
        checks++; if (protocol_error !== 1'b1) begin errors++; $display("FAIL perr_set: got %b want 1", protocol_error); end
        checks++; if (owner !== 2'd0 || trn_td !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL perr_mux1: owner=%0d td=%h", owner, trn_td); end
        driving_interface[2]  = 1'b0;
        req_trn_td[191:128]   = '0;
        req_trn_tsrc_rdy_n[2] = 1'b1;
        step();
        checks++; if (protocol_error !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %b want 1", protocol_error); end
        test_interrupt();
        driving_interface[0]  = 1'b0;
        req_trn_td[63:0]      = '0;
        req_trn_tsrc_rdy_n[0] = 1'b1;
        step();
        checks++; if (my_turn !== 3'b000) begin errors++; $display("FAIL perr_gap: got %b want 000", my_turn); end
        step();
        checks++; if (my_turn !== 3'b010) begin errors++; $display("FAIL perr_next: got %b want 010", my_turn); end
    endtask

    task automatic test_timeout();
        wait_for_turn(2);
        step();
        driving_interface[2]  = 1'b1;
        req_trn_td[191:128]   = 64'hCAFE;
        req_trn_tsrc_rdy_n[2] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++; if (my_turn !== 3'b000 || owner !== 2'd2) begin errors++; $display("FAIL tmo_hold[%0d]: turn=%b owner=%0d want 000/2", i, my_turn, owner); end
            if (i == 8) begin
                checks++; if (own_timeout !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b want 0", own_timeout); end
            end
            if (i == 9) begin
                checks++; if (own_timeout !== 1'b1) begin errors++; $display("FAIL tmo_set: got %b want 1", own_timeout); end
            end
        end
        driving_interface[2]  = 1'b0;
        req_trn_td[191:128]   = '0;
        req_trn_tsrc_rdy_n[2] = 1'b1;
        step();
        step();
        checks++; if (my_turn !== 3'b001) begin errors++; $display("FAIL tmo_next: got %b want 001", my_turn); end
        checks++; if (own_timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", own_timeout); end
    endtask

    task automatic test_window_tie();
        wait_for_turn(1);
        step(); step(); step();
        driving_interface[1] = 1'b1;
        step();
        checks++; if (my_turn !== 3'b000 || owner !== 2'd1) begin errors++; $display("FAIL tie_own: turn=%b owner=%0d want 000/1", my_turn, owner); end
        driving_interface[1] = 1'b0;
        step();
        step();
        checks++; if (my_turn !== 3'b100) begin errors++; $display("FAIL tie_next: got %b want 100", my_turn); end
    endtask

    task automatic test_mid_reset();
        wait_for_turn(0);
        step();
        driving_interface[0]   = 1'b1;
        req_trn_td[63:0]       = 64'hFEED_FACE_0000_0001;
        req_trn_trem_n[7:0]    = 8'h00;
        req_trn_tsof_n[0]      = 1'b0;
        req_trn_tsrc_rdy_n[0]  = 1'b0;
        req_cfg_interrupt_n[0] = 1'b0;
        step();
        step();
        checks++; if (trn_td !== 64'hFEED_FACE_0000_0001 || trn_trem_n !== 8'h00) begin errors++; $display("FAIL mr_pre: td=%h trem=%h", trn_td, trn_trem_n); end
        reset = 1'b1;
        #1;
        checks++; if (trn_td !== 64'h0 || trn_trem_n !== 8'hFF) begin errors++; $display("FAIL mr_idle_data: td=%h trem=%h want 0/ff", trn_td, trn_trem_n); end
        checks++; if (trn_tsof_n !== 1'b1 || trn_tsrc_rdy_n !== 1'b1 || cfg_interrupt_n !== 1'b1) begin errors++; $display("FAIL mr_idle_ctl: sof=%b src=%b int=%b want 1/1/1", trn_tsof_n, trn_tsrc_rdy_n, cfg_interrupt_n); end
        checks++; if (my_turn !== 3'b000 || owner !== 2'd0) begin errors++; $display("FAIL mr_regs: turn=%b owner=%0d want 000/0", my_turn, owner); end
        checks++; if (protocol_error !== 1'b0 || own_timeout !== 1'b0) begin errors++; $display("FAIL mr_sticky_clr: perr=%b tmo=%b want 0/0", protocol_error, own_timeout); end
        idle_inputs();
        step();
        step();
        #2;
        reset = 1'b0;
        step();
        checks++; if (my_turn !== 3'b001 || owner !== 2'd0) begin errors++; $display("FAIL mr_first_offer: turn=%b owner=%0d want 001/0", my_turn, owner); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_rotation();
        test_handshake();
        test_protocol_error();
        test_timeout();
        test_window_tie();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
